product_accumulator: RTL and testbench

- Downstream consumer of the pipelined signed Booth multiplier.
- Tracks issued operand pairs through a valid/last delay line matched to the multiplier's fixed latency, captures each product when it emerges, and sums a vector of products into a wide signed accumulator.
- Presents each completed dot-product on a valid/ready output.
- Supplies in_ready back to the operand issuer, because the multiplier pipeline cannot stall.

---
 rtl/product_accumulator.sv | 134 +++++++++++++
 tb/tb_product_accumulator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums signed products from a fixed-latency multiplier into dot-product results
// Ports:
//   clk           single clock, all state on the rising edge
//   rst           synchronous reset, active-high
//   in_valid      issuer presents an operand pair to the multiplier this cycle
//   in_last       qualifies in_valid; final pair of a vector
//   in_ready      issue permitted this cycle (issue = in_valid && in_ready)
//   prod          multiplier product, signed 2*WIDTH bits
//   out_valid     result registers hold a completed vector
//   out_ready     consumer accepts the result
//   out_sum       signed sum of the vector's products
//   out_count     number of products in the vector
//   out_overflow  vector exceeded 2^LEN_WIDTH elements; out_sum not guaranteed
module product_accumulator #(
  parameter int WIDTH     = 8,
  parameter int LATENCY   = WIDTH + 1,
  parameter int LEN_WIDTH = 8,
  parameter int ACC_WIDTH = 2*WIDTH + LEN_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  input  logic signed [2*WIDTH-1:0]   prod,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_sum,
  output logic [LEN_WIDTH:0]          out_count,
  output logic                        out_overflow
);

  typedef enum logic {EMPTY, ACCUM} state_t;

  localparam logic [LEN_WIDTH:0] CNT_MAX = {1'b1, {LEN_WIDTH{1'b0}}};

  state_t                      state;
  logic [LATENCY-1:0]          dl_v;
  logic [LATENCY-1:0]          dl_l;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH:0]          cnt;
  logic                        ovf;
  logic                        last_inflight;

  logic                        issue;
  logic                        tv;
  logic                        tl;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic [LEN_WIDTH:0]          cnt_base;
  logic [LEN_WIDTH:0]          cnt_next;
  logic                        ovf_base;
  logic                        ovf_next;

  // A pending last in the pipe, or an unaccepted result, blocks new issues so
  // that a completion can never land on top of a result still being held.
  assign in_ready = !last_inflight && !(out_valid && !out_ready);
  assign issue    = in_valid && in_ready;

  // Tail of the delay line lines up with prod.
  assign tv = dl_v[LATENCY-1];
  assign tl = dl_l[LATENCY-1];

  always_comb begin
    prod_ext = ACC_WIDTH'(prod);
    // The first element of a vector starts from zero regardless of register contents.
    acc_base = (state == EMPTY) ? '0 : acc;
    cnt_base = (state == EMPTY) ? '0 : cnt;
    ovf_base = (state == ACCUM) && ovf;
    acc_next = acc_base + prod_ext;
    if (cnt_base == CNT_MAX) begin
      // Already at the maximum length: any further product overflows the vector.
      cnt_next = CNT_MAX;
      ovf_next = 1'b1;
    end else begin
      cnt_next = cnt_base + 1'b1;
      ovf_next = ovf_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      dl_v          <= '0;
      dl_l          <= '0;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      last_inflight <= 1'b0;
      out_valid     <= 1'b0;
      out_sum       <= '0;
      out_count     <= '0;
      out_overflow  <= 1'b0;
    end else begin
      dl_v[0] <= issue;
      dl_l[0] <= in_last;
      for (int i = 1; i < LATENCY; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_l[i] <= dl_l[i-1];
      end

      // A new last issue wins over the tail last retiring on the same edge.
      if (issue && in_last) begin
        last_inflight <= 1'b1;
      end else if (tv && tl) begin
        last_inflight <= 1'b0;
      end

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (tv) begin
        if (tl) begin
          out_sum      <= acc_next;
          out_count    <= cnt_next;
          out_overflow <= ovf_next;
          out_valid    <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
          ovf          <= 1'b0;
          state        <= EMPTY;
        end else begin
          acc   <= acc_next;
          cnt   <= cnt_next;
          ovf   <= ovf_next;
          state <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - testbench for product_accumulator with a behavioural multiplier pipe
module tb_product_accumulator;

  localparam int WIDTH     = 4;
  localparam int LATENCY   = 5;
  localparam int LEN_WIDTH = 2;
  localparam int ACC_WIDTH = 2*WIDTH + LEN_WIDTH;
  localparam int MAXLEN    = 1 << LEN_WIDTH;
  localparam int NVEC      = 40;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        in_valid;
  logic                        in_last;
  logic                        in_ready;
  logic signed [2*WIDTH-1:0]   prod;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_sum;
  logic [LEN_WIDTH:0]          out_count;
  logic                        out_overflow;

  logic signed [WIDTH-1:0]     op_a;
  logic signed [WIDTH-1:0]     op_b;
  logic signed [2*WIDTH-1:0]   mul_pipe [LATENCY];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_issue_cyc = 0;

  typedef struct {
    int    n;
    int    a [6];
    int    b [6];
    int    sum;
    int    cnt;
    bit    ovf;
    string name;
  } vec_t;

  typedef struct {
    int sum;
    int cnt;
    bit ovf;
  } res_t;

  vec_t tbl [8];
  res_t exp_q [$];

  product_accumulator #(
    .WIDTH(WIDTH), .LATENCY(LATENCY), .LEN_WIDTH(LEN_WIDTH), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .prod(prod), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product of the operands presented LATENCY edges earlier.
  always @(posedge clk) begin
    mul_pipe[0] <= op_a * op_b;
    for (int i = 1; i < LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
    cyc <= cyc + 1;
  end
  assign prod = mul_pipe[LATENCY-1];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input int a, input int b, input bit last);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("issue_wait_timeout", 1, 0);
    in_valid = 1'b1;
    in_last  = last;
    op_a     = WIDTH'(a);
    op_b     = WIDTH'(b);
    @(negedge clk);
    last_issue_cyc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    op_a     = '0;
    op_b     = '0;
  endtask

  task automatic wait_result(input string name, input int sum, input int cnt,
                             input bit ovf, input bit chk_sum, input bit chk_lat);
    int guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      if (chk_lat) check({name, "_latency"}, cyc - last_issue_cyc + 1, LATENCY + 1);
      if (chk_sum) check({name, "_sum"}, longint'(out_sum), sum);
      check({name, "_count"}, out_count, cnt);
      check({name, "_ovf"}, out_overflow, ovf);
    end
  endtask

  initial begin
    int n_ready_low;
    int seen_valid;
    int vec_done;
    int pos;
    int vlen;
    int run_sum;
    int guard;
    int a;
    int b;
    res_t e;

    tbl[0] = '{3, '{3, -1, 5, 0, 0, 0}, '{2, 4, -3, 0, 0, 0}, -13, 3, 1'b0, "three_pairs"};
    tbl[1] = '{1, '{7, 0, 0, 0, 0, 0}, '{7, 0, 0, 0, 0, 0}, 49, 1, 1'b0, "seven_sq"};
    tbl[2] = '{1, '{-8, 0, 0, 0, 0, 0}, '{-8, 0, 0, 0, 0, 0}, 64, 1, 1'b0, "neg8_sq"};
    tbl[3] = '{1, '{2, 0, 0, 0, 0, 0}, '{3, 0, 0, 0, 0, 0}, 6, 1, 1'b0, "two_three"};
    tbl[4] = '{5, '{1, 1, 1, 1, 1, 0}, '{1, 1, 1, 1, 1, 0}, 5, 4, 1'b1, "overflow5"};
    tbl[5] = '{4, '{1, 1, 1, 1, 0, 0}, '{1, 1, 1, 1, 0, 0}, 4, 4, 1'b0, "after_ovf4"};
    tbl[6] = '{4, '{-8, -8, -8, -8, 0, 0}, '{7, 7, 7, 7, 0, 0}, -224, 4, 1'b0, "neg_full4"};
    tbl[7] = '{2, '{-3, 6, 0, 0, 0, 0}, '{-5, -2, 0, 0, 0, 0}, 3, 2, 1'b0, "mixed_two"};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0;
    for (int i = 0; i < LATENCY; i++) mul_pipe[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", longint'(out_sum), 0);
    check("reset_out_count", out_count, 0);
    check("reset_out_ovf", out_overflow, 0);
    check("reset_in_ready", in_ready, 1);

    // Table-driven vectors, issued back to back within each vector.
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < tbl[v].n; k++) issue(tbl[v].a[k], tbl[v].b[k], k == tbl[v].n - 1);
      wait_result(tbl[v].name, tbl[v].sum, tbl[v].cnt, tbl[v].ovf, !tbl[v].ovf, 1'b1);
      @(negedge clk);
      check({tbl[v].name, "_drop"}, out_valid, 0);
    end

    // Output stall: result and in_ready held while out_ready is low.
    out_ready = 1'b0;
    issue(2, 5, 1'b1);
    wait_result("stall", 10, 1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_sum", longint'(out_sum), 10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", out_valid, 0);
    check("stall_release_in_ready", in_ready, 1);

    // Back-to-back vectors: in_ready low while the first last is in flight.
    issue(2, 3, 1'b1);
    n_ready_low = 0;
    while (!in_ready && n_ready_low < 50) begin
      @(negedge clk);
      n_ready_low++;
    end
    check("b2b_ready_low_cycles", n_ready_low, LATENCY);
    check("b2b_first_valid", out_valid, 1);
    check("b2b_first_sum", longint'(out_sum), 6);
    issue(1, 1, 1'b1);
    wait_result("b2b_second", 1, 1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);

    // Reset mid-vector discards everything in flight.
    issue(4, 4, 1'b0);
    issue(4, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen_valid++;
      @(negedge clk);
    end
    check("rst_mid_no_valid", seen_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    issue(1, 2, 1'b1);
    wait_result("rst_mid_after", 2, 1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);

    // Randomised traffic against a scoreboard of per-vector sums.
    vec_done = 0; pos = 0; run_sum = 0; guard = 0;
    vlen = $urandom_range(1, 6);
    while (!(vec_done == NVEC && exp_q.size() == 0) && guard < 20000) begin
      @(negedge clk);
      guard++;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = 1'b0; in_last = 1'b0; op_a = '0; op_b = '0;
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_count", out_count, e.cnt);
          check("rnd_ovf", out_overflow, e.ovf);
          if (!e.ovf) check("rnd_sum", longint'(out_sum), e.sum);
        end
      end
      if (vec_done < NVEC && in_ready && $urandom_range(0, 4) != 0) begin
        a = int'($urandom_range(0, 15)) - 8;
        b = int'($urandom_range(0, 15)) - 8;
        in_valid = 1'b1;
        in_last  = (pos == vlen - 1);
        op_a = WIDTH'(a);
        op_b = WIDTH'(b);
        run_sum += a * b;
        pos++;
        if (pos == vlen) begin
          e.sum = run_sum;
          e.cnt = (pos > MAXLEN) ? MAXLEN : pos;
          e.ovf = (pos > MAXLEN);
          exp_q.push_back(e);
          vec_done++;
          pos = 0; run_sum = 0;
          vlen = $urandom_range(1, 6);
        end
      end else if (!in_ready && $urandom_range(0, 1) == 1) begin
        // Refused issues must not enter the pipe.
        in_valid = 1'b1;
        in_last  = $urandom_range(0, 1) == 1;
        op_a = WIDTH'($urandom_range(0, 15));
        op_b = WIDTH'($urandom_range(0, 15));
      end
    end
    check("rnd_all_results_seen", exp_q.size(), 0);
    check("rnd_all_vectors_issued", vec_done, NVEC);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rnd_final_idle_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
